mem_port_arbiter: RTL and testbench

- Shares the single 128-bit line-granular memory port between the read-only instruction cache (I-side) and the read/write data cache (D-side).
- Sits between both cache controllers' memory interfaces and the memory model or bus.
- Grants one requester at a time and holds the grant until that transaction's `mem_ready`.
- Inserts one release cycle after each transaction so a requester's late-dropping request is never re-granted.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter and the cache controllers
// that sit on either side of it.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_I = 2'b01,
      GRANT_D = 2'b10,
      RELEASE = 2'b11
   } arb_state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one line-granular memory port between the I-cache and D-cache.
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates the winner of a tie instead of favouring D.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_addr,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   arb_state_e state, state_nxt;
   logic       last_grant, last_grant_nxt;
   logic       i_req, d_req;
   logic       winner;

   assign i_req = i_mem_read;
   assign d_req = d_mem_read | d_mem_write;

   // Tie resolution is the only place the build option changes behaviour.
`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign winner = (i_req & d_req) ? ~last_grant : d_req;
`else
   assign winner = d_req ? GNT_D : GNT_I;
`endif

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state      <= IDLE;
         last_grant <= GNT_I;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (i_req | d_req) begin
               state_nxt      = (winner == GNT_D) ? GRANT_D : GRANT_I;
               last_grant_nxt = winner;
            end
         end
         GRANT_I, GRANT_D: begin
            // A request dropped without ready is a requester bug; keep waiting for memory.
            if (mem_ready) state_nxt = RELEASE;
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      i_mem_ready = 1'b0;
      d_mem_ready = 1'b0;
      case (state)
         GRANT_I: begin
            mem_read    = i_mem_read;
            mem_addr    = i_mem_addr;
            i_mem_ready = mem_ready;
         end
         GRANT_D: begin
            mem_read    = d_mem_read;
            mem_write   = d_mem_write;
            mem_addr    = d_mem_addr;
            mem_wdata   = d_mem_wdata;
            d_mem_ready = mem_ready;
         end
         default: ;
      endcase
   end

   // Read data goes to both caches; each only samples it on its own ready.
   assign i_mem_rdata = mem_rdata;
   assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;

   logic          clk = 1'b0;
   logic          proc_reset;
   logic          i_mem_read;
   logic [AW-1:0] i_mem_addr;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_ready;
   logic          d_mem_read;
   logic          d_mem_write;
   logic [AW-1:0] d_mem_addr;
   logic [DW-1:0] d_mem_wdata;
   logic [DW-1:0] d_mem_rdata;
   logic          d_mem_ready;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .proc_reset(proc_reset),
      .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
      .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
      .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: who currently owns the port (0 none, 1 I, 2 D), whether the
   // mandatory dead cycle after a transaction is pending, and who won last.
   int owner;
   bit dead_cycle;
   int last_won;
   int obs_log[$];
   int i_pulses, d_pulses;
   bit i_seen, d_seen, i_late, d_late;

   function automatic void model_reset();
      owner = 0;
      dead_cycle = 0;
      last_won = 1;
   endfunction

   function automatic int tie_pick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (last_won == 2) ? 1 : 2;
`else
      return 2;
`endif
   endfunction

   // One clock: compare outputs mid-cycle, then advance the model over the edge.
   task automatic step();
      logic          e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      bit            ir, dr;
      int            n_owner;
      bit            n_dead;
      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (owner == 1) begin
         e_rd = i_mem_read; e_addr = i_mem_addr;
      end else if (owner == 2) begin
         e_rd = d_mem_read; e_wr = d_mem_write; e_addr = d_mem_addr; e_wd = d_mem_wdata;
      end
      check_val("mem_read", DW'(mem_read), DW'(e_rd));
      check_val("mem_write", DW'(mem_write), DW'(e_wr));
      check_val("mem_addr", DW'(mem_addr), DW'(e_addr));
      check_val("mem_wdata", mem_wdata, e_wd);
      check_val("i_mem_ready", DW'(i_mem_ready), DW'(mem_ready && owner == 1));
      check_val("d_mem_ready", DW'(d_mem_ready), DW'(mem_ready && owner == 2));
      check_val("i_mem_rdata", i_mem_rdata, mem_rdata);
      check_val("d_mem_rdata", d_mem_rdata, mem_rdata);
      check_val("rd_wr_exclusive", DW'(mem_read & mem_write), '0);
      i_seen = i_mem_ready;
      d_seen = d_mem_ready;
      if (i_mem_ready) begin i_pulses++; obs_log.push_back(1); end
      if (d_mem_ready) begin d_pulses++; obs_log.push_back(2); end

      n_owner = owner;
      n_dead  = dead_cycle;
      ir = i_mem_read;
      dr = d_mem_read | d_mem_write;
      if (owner != 0) begin
         if (mem_ready) begin n_owner = 0; n_dead = 1'b1; end
      end else if (dead_cycle) begin
         n_dead = 1'b0;
      end else if (ir || dr) begin
         n_owner  = (ir && dr) ? tie_pick() : (ir ? 1 : 2);
         last_won = n_owner;
      end
      @(posedge clk);
      #1;
      owner = n_owner;
      dead_cycle = n_dead;
   endtask

   // One randomized cycle of both cache agents and the memory.
   task automatic auto_cycle(input int rate, input int late_pct, input int rdy_pct);
      mem_ready = ($urandom_range(99) < rdy_pct);
      mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      if (i_seen) begin
         if ($urandom_range(99) < late_pct) i_late = 1'b1;
         else i_mem_read = 1'b0;
      end else if (i_late) begin
         i_mem_read = 1'b0; i_late = 1'b0;
      end else if (!i_mem_read && $urandom_range(99) < rate) begin
         i_mem_read = 1'b1; i_mem_addr = AW'($urandom());
      end
      if (d_seen) begin
         if ($urandom_range(99) < late_pct) d_late = 1'b1;
         else begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      end else if (d_late) begin
         d_mem_read = 1'b0; d_mem_write = 1'b0; d_late = 1'b0;
      end else if (!(d_mem_read | d_mem_write) && $urandom_range(99) < rate) begin
         if ($urandom_range(1) == 1) d_mem_write = 1'b1;
         else d_mem_read = 1'b1;
         d_mem_addr  = AW'($urandom());
         d_mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
   endtask

   initial begin
      int exp_pat[6];
      proc_reset = 1'b1;
      i_mem_read = 1'b0; i_mem_addr = '0;
      d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b1;
      i_late = 1'b0; d_late = 1'b0;
      model_reset();

      // Reset: everything quiet even with memory ready asserted.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_mem_read", DW'(mem_read), '0);
      check_val("rst_mem_write", DW'(mem_write), '0);
      check_val("rst_mem_addr", DW'(mem_addr), '0);
      check_val("rst_mem_wdata", mem_wdata, '0);
      check_val("rst_i_ready", DW'(i_mem_ready), '0);
      check_val("rst_d_ready", DW'(d_mem_ready), '0);
      proc_reset = 1'b0;
      mem_ready = 1'b0;
      step();
      step();

      // I-only fill, memory answers on the fourth granted cycle.
      i_pulses = 0; d_pulses = 0;
      i_mem_read = 1'b1; i_mem_addr = 28'h000_0040;
      step();
      check_val("i_only_read", DW'(mem_read), 1);
      check_val("i_only_addr", DW'(mem_addr), 128'h40);
      for (int k = 1; k <= 4; k++) begin
         mem_ready = (k == 4);
         if (k == 4) mem_rdata = {16{8'hA5}};
         step();
      end
      mem_ready = 1'b0; i_mem_read = 1'b0;
      step(); step();
      check_val("i_only_i_pulses", DW'(i_pulses), 1);
      check_val("i_only_d_pulses", DW'(d_pulses), 0);

      // Simultaneous I read and D write-back: D first, then a dead cycle, then I.
      obs_log.delete();
      i_mem_read = 1'b1; i_mem_addr = 28'h10;
      d_mem_write = 1'b1; d_mem_addr = 28'h20; d_mem_wdata = 128'h1234;
      step();
      check_val("tie_d_write", DW'(mem_write), 1);
      check_val("tie_d_read", DW'(mem_read), 0);
      check_val("tie_d_wdata", mem_wdata, 128'h1234);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; d_mem_write = 1'b0;
      check_val("tie_release_read", DW'(mem_read), 0);
      check_val("tie_release_write", DW'(mem_write), 0);
      step();
      check_val("tie_idle_read", DW'(mem_read), 0);
      step();
      check_val("tie_i_read", DW'(mem_read), 1);
      check_val("tie_i_addr", DW'(mem_addr), 128'h10);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; i_mem_read = 1'b0;
      step(); step();
      check_val("tie_order_len", DW'(obs_log.size()), 2);
      if (obs_log.size() == 2) begin
         check_val("tie_order_0", DW'(obs_log[0]), 2);
         check_val("tie_order_1", DW'(obs_log[1]), 1);
      end

      // D write-back followed by D fill.
      obs_log.delete();
      d_mem_write = 1'b1; d_mem_addr = 28'h30; d_mem_wdata = {4{32'hCAFE_0001}};
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; d_mem_write = 1'b0;
      step();
      d_mem_read = 1'b1; d_mem_addr = 28'h50;
      check_val("b2b_gap_read", DW'(mem_read), 0);
      step();
      check_val("b2b_fill_read", DW'(mem_read), 1);
      check_val("b2b_fill_write", DW'(mem_write), 0);
      check_val("b2b_fill_addr", DW'(mem_addr), 128'h50);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; d_mem_read = 1'b0;
      step(); step();
      check_val("b2b_txn_count", DW'(obs_log.size()), 2);

      // Spurious ready in idle, then ready held through the dead cycle.
      i_pulses = 0; d_pulses = 0;
      mem_ready = 1'b1;
      repeat (3) step();
      check_val("spur_idle_pulses", DW'(i_pulses + d_pulses), 0);
      mem_ready = 1'b0;
      i_mem_read = 1'b1; i_mem_addr = 28'h0AB_CDEF;
      step();
      check_val("spur_grant_read", DW'(mem_read), 1);
      mem_ready = 1'b1;
      step();
      i_mem_read = 1'b0;
      step(); step();
      mem_ready = 1'b0;
      check_val("spur_release_pulses", DW'(i_pulses), 1);

      // Reset in the middle of a D grant.
      d_mem_read = 1'b1; d_mem_addr = 28'h77;
      step();
      check_val("midrst_pre_read", DW'(mem_read), 1);
      #2;
      proc_reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      check_val("midrst_read", DW'(mem_read), 0);
      check_val("midrst_addr", DW'(mem_addr), 0);
      check_val("midrst_d_ready", DW'(d_mem_ready), 0);
      @(posedge clk);
      #1;
      proc_reset = 1'b0; mem_ready = 1'b0; d_mem_read = 1'b0;
      model_reset();
      step();

      // Both sides requesting back to back: winner order across six transactions.
      obs_log.delete();
      i_mem_read = 1'b1; i_mem_addr = 28'h111;
      d_mem_read = 1'b1; d_mem_addr = 28'h222;
      for (int c = 0; c < 400 && obs_log.size() < 6; c++) auto_cycle(100, 0, 50);
      check_val("arb_txn_count", DW'(obs_log.size() >= 6), 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_pat = '{2, 1, 2, 1, 2, 1};
`else
      exp_pat = '{2, 2, 2, 2, 2, 2};
`endif
      for (int k = 0; k < 6 && k < obs_log.size(); k++)
         check_val($sformatf("arb_grant_%0d", k), DW'(obs_log[k]), DW'(exp_pat[k]));

      // Long random run with late drops and spurious readies.
      for (int c = 0; c < 3000; c++) auto_cycle(30, 40, 35);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
